axi_wr_req_gen: RTL and testbench



---
 rtl/axi_wr_req_gen.sv | 198 +++++++++++++++++++
 tb/tb_axi_wr_req_gen.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_wr_req_gen.sv
// Write-command sequencer feeding the AXI write master: issues AW, streams W beats
// with computed byte strobes, waits for B (with timeout) and pulses done.
module axi_wr_req_gen #(
  parameter int AW      = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [AW-1:0] cmd_addr,
  input  logic [7:0]    cmd_len,
  input  logic [2:0]    cmd_size,
  input  logic [1:0]    cmd_burst,
  input  logic          din_valid,
  output logic          din_ready,
  input  logic [63:0]   din_data,
  output logic [AW-1:0] awaddr_in,
  output logic [7:0]    awlen_in,
  output logic [2:0]    awsize_in,
  output logic [1:0]    awburst_in,
  output logic          awvalid_in,
  output logic [63:0]   wdata_in,
  output logic [7:0]    wstrb_in,
  output logic          wvalid_in,
  output logic          bready_in,
  input  logic          axi_awvalid,
  input  logic          axi_awready,
  input  logic          axi_wvalid,
  input  logic          axi_wready,
  input  logic          axi_wlast,
  input  logic          axi_bvalid,
  input  logic [1:0]    axi_bresp,
  output logic          done,
  output logic [1:0]    done_resp,
  output logic          wlast_err,
  output logic          busy
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_AW   = 3'd1;
  localparam logic [2:0] S_W    = 3'd2;
  localparam logic [2:0] S_B    = 3'd3;
  localparam logic [2:0] S_RESP = 3'd4;

  localparam int TW = $clog2(TIMEOUT);

  logic [2:0]    state;
  logic [AW-1:0] cur_addr;
  logic [AW-1:0] nxt_addr;
  logic [7:0]    beat_cnt;
  logic [TW-1:0] tmo_cnt;
  logic          beat_acc;
  logic          last_beat;
  logic          illegal;

  // Lanes from the beat address up to the end of its size-aligned container.
  function automatic logic [7:0] lane_strb(input logic [2:0] a, input logic [2:0] size);
    logic [3:0] mask;
    logic [3:0] lo;
    logic [3:0] hi;
    logic [7:0] s;
    mask = (4'd1 << size) - 4'd1;
    lo   = {1'b0, a};
    hi   = (lo & ~mask) + mask;
    s    = 8'd0;
    for (int i = 0; i < 8; i++) begin
      s[i] = (4'(i) >= lo) && (4'(i) <= hi);
    end
    return s;
  endfunction

  function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] cur, input logic [AW-1:0] start,
                                               input logic [7:0] len, input logic [2:0] size,
                                               input logic [1:0] burst);
    logic [AW-1:0] step;
    logic [AW-1:0] total;
    logic [AW-1:0] bound;
    logic [AW-1:0] lin;
    logic [AW-1:0] res;
    step  = AW'(1) << size;
    total = (AW'(len) + AW'(1)) << size;
    lin   = (cur & ~(step - AW'(1))) + step;
    bound = start & ~(total - AW'(1));
    case (burst)
      2'd1:    res = lin;
      2'd2:    res = (lin == bound + total) ? bound : lin;
      default: res = cur;
    endcase
    return res;
  endfunction

  assign cmd_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign wvalid_in = (state == S_W) && din_valid;
  assign wdata_in  = (state == S_W) ? din_data : 64'd0;
  assign din_ready = beat_acc;

  // Beat acceptance, command legality and next beat address
  always_comb begin
    beat_acc  = (state == S_W) && axi_wvalid && axi_wready;
    last_beat = (beat_cnt == awlen_in);
    illegal   = (cmd_size > 3'd3) || (cmd_burst == 2'd3) ||
                ((cmd_burst == 2'd2) && !((cmd_len == 8'd1) || (cmd_len == 8'd3) ||
                                          (cmd_len == 8'd7) || (cmd_len == 8'd15)));
    nxt_addr  = next_addr(cur_addr, awaddr_in, awlen_in, awsize_in, awburst_in);
  end

  // Sequencer state, latched command and registered bus-side outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cur_addr   <= '0;
      beat_cnt   <= 8'd0;
      tmo_cnt    <= '0;
      awaddr_in  <= '0;
      awlen_in   <= 8'd0;
      awsize_in  <= 3'd0;
      awburst_in <= 2'd0;
      awvalid_in <= 1'b0;
      wstrb_in   <= 8'd0;
      bready_in  <= 1'b0;
      done       <= 1'b0;
      done_resp  <= 2'd0;
      wlast_err  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            if (illegal) begin
              state     <= S_RESP;
              done      <= 1'b1;
              done_resp <= 2'b10;
            end else begin
              state      <= S_AW;
              awaddr_in  <= cmd_addr;
              awlen_in   <= cmd_len;
              awsize_in  <= cmd_size;
              awburst_in <= cmd_burst;
              awvalid_in <= 1'b1;
              cur_addr   <= cmd_addr;
            end
          end
        end
        S_AW: begin
          if (axi_awvalid && axi_awready) begin
            state      <= S_W;
            awvalid_in <= 1'b0;
            beat_cnt   <= 8'd0;
            wstrb_in   <= lane_strb(cur_addr[2:0], awsize_in);
          end
        end
        S_W: begin
          if (beat_acc) begin
            beat_cnt <= beat_cnt + 8'd1;
            if (axi_wlast != last_beat) begin
              wlast_err <= 1'b1;
            end
            if (last_beat) begin
              state     <= S_B;
              wstrb_in  <= 8'd0;
              bready_in <= 1'b1;
              tmo_cnt   <= '0;
            end else begin
              cur_addr <= nxt_addr;
              wstrb_in <= lane_strb(nxt_addr[2:0], awsize_in);
            end
          end
        end
        S_B: begin
          // A response arriving on the timeout cycle still takes priority.
          if (axi_bvalid) begin
            state     <= S_RESP;
            bready_in <= 1'b0;
            done      <= 1'b1;
            done_resp <= axi_bresp;
          end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
            state     <= S_RESP;
            bready_in <= 1'b0;
            done      <= 1'b1;
            done_resp <= 2'b11;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        S_RESP: begin
          state <= S_IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_wr_req_gen.sv
// Randomized bench for axi_wr_req_gen: a pass-through master model plus a
// beat-address/strobe reference computed directly from the burst rules.
module tb_axi_wr_req_gen;

  localparam int TO = 16;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic [2:0]  cmd_size;
  logic [1:0]  cmd_burst;
  logic        din_valid;
  logic        din_ready;
  logic [63:0] din_data;
  logic [31:0] awaddr_in;
  logic [7:0]  awlen_in;
  logic [2:0]  awsize_in;
  logic [1:0]  awburst_in;
  logic        awvalid_in;
  logic [63:0] wdata_in;
  logic [7:0]  wstrb_in;
  logic        wvalid_in;
  logic        bready_in;
  logic        axi_awvalid;
  logic        axi_awready;
  logic        axi_wvalid;
  logic        axi_wready;
  logic        axi_wlast;
  logic        axi_bvalid;
  logic [1:0]  axi_bresp;
  logic        done;
  logic [1:0]  done_resp;
  logic        wlast_err;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;
  bit exp_werr = 1'b0;

  axi_wr_req_gen #(.AW(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .cmd_size(cmd_size), .cmd_burst(cmd_burst),
    .din_valid(din_valid), .din_ready(din_ready), .din_data(din_data),
    .awaddr_in(awaddr_in), .awlen_in(awlen_in), .awsize_in(awsize_in), .awburst_in(awburst_in),
    .awvalid_in(awvalid_in), .wdata_in(wdata_in), .wstrb_in(wstrb_in), .wvalid_in(wvalid_in),
    .bready_in(bready_in),
    .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_wvalid(axi_wvalid),
    .axi_wready(axi_wready), .axi_wlast(axi_wlast), .axi_bvalid(axi_bvalid), .axi_bresp(axi_bresp),
    .done(done), .done_resp(done_resp), .wlast_err(wlast_err), .busy(busy)
  );

  // The master forwards valids unchanged; the bench plays the slave side.
  assign axi_awvalid = awvalid_in;
  assign axi_wvalid  = wvalid_in;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_addr(input logic [31:0] a, input logic [7:0] l,
                                         input logic [2:0] s, input logic [1:0] b, input int n);
    logic [31:0] sz;
    logic [31:0] al;
    logic [31:0] total;
    logic [31:0] bound;
    sz    = 32'd1 << s;
    al    = a - (a % sz);
    total = (32'(l) + 32'd1) * sz;
    bound = a - (a % total);
    if (b == 2'd0 || n == 0) return a;
    if (b == 2'd1) return al + 32'(n) * sz;
    return bound + ((al - bound + 32'(n) * sz) % total);
  endfunction

  function automatic logic [7:0] m_strb(input logic [31:0] a, input logic [2:0] s);
    int sz;
    int lo;
    int hi;
    logic [7:0] r;
    sz = 1 << s;
    lo = int'(a % 32'd8);
    hi = int'((a - (a % 32'(sz))) % 32'd8) + sz - 1;
    r  = 8'd0;
    for (int i = 0; i < 8; i++) if (i >= lo && i <= hi) r[i] = 1'b1;
    return r;
  endfunction

  task automatic run_cmd(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s,
                         input logic [1:0] b, input int bdly, input logic [1:0] br,
                         input bit full_rate, input bit bad_last);
    bit ill;
    bit hs;
    bit pend;
    bit fin;
    bit acc;
    int n;
    int k;
    int cyc;
    int lat;
    logic [1:0] er;
    ill = (s > 3'd3) || (b == 2'd3) ||
          (b == 2'd2 && !(l == 8'd1 || l == 8'd3 || l == 8'd7 || l == 8'd15));
    cmd_valid = 1'b1; cmd_addr = a; cmd_len = l; cmd_size = s; cmd_burst = b;
    check("cmd_ready", 64'(cmd_ready), 64'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 1;
    if (ill) begin
      check("ill_done", 64'(done), 64'd1);
      check("ill_resp", 64'(done_resp), 64'd2);
      check("ill_awvalid", 64'(awvalid_in), 64'd0);
      @(negedge clk);
      check("ill_done_low", 64'(done), 64'd0);
      check("ill_awvalid2", 64'(awvalid_in), 64'd0);
      return;
    end
    check("awvalid_rise", 64'(awvalid_in), 64'd1);
    check("awaddr", 64'(awaddr_in), 64'(a));
    check("aw_len_size_burst", 64'({awlen_in, awsize_in, awburst_in}), 64'({l, s, b}));
    hs = 1'b0; cyc = 0;
    while (!hs && cyc < 50) begin
      axi_awready = (full_rate || cyc > 5) ? 1'b1 : 1'($urandom_range(0, 1));
      hs = awvalid_in && axi_awready;
      @(negedge clk); lat++; cyc++;
    end
    axi_awready = 1'b0;
    if (!hs) check("aw_handshake", 64'd0, 64'd1);
    check("awvalid_fall", 64'(awvalid_in), 64'd0);
    n = 0; cyc = 0; pend = 1'b0;
    while (n <= int'(l) && cyc < 500) begin
      if (!pend) begin
        din_valid = full_rate ? 1'b1 : 1'($urandom_range(0, 1));
        din_data  = {$urandom, $urandom};
        pend      = din_valid;
      end
      axi_wready = full_rate ? 1'b1 : ($urandom_range(0, 3) != 0);
      axi_wlast  = (n == int'(l)) ^ (bad_last && n == 0);
      #1;
      check("wvalid", 64'(wvalid_in), 64'(din_valid));
      acc = pend && axi_wready;
      if (acc) begin
        check("din_ready", 64'(din_ready), 64'd1);
        check("wdata", wdata_in, din_data);
        check("wstrb", 64'(wstrb_in), 64'(m_strb(m_addr(a, l, s, b, n), s)));
      end else begin
        check("din_ready_idle", 64'(din_ready), 64'd0);
      end
      @(negedge clk); lat++; cyc++;
      if (acc) begin n++; pend = 1'b0; end
    end
    din_valid = 1'b0; axi_wready = 1'b0; axi_wlast = 1'b0;
    if (n <= int'(l)) check("w_beats", 64'(n), 64'(l) + 64'd1);
    if (bad_last) exp_werr = 1'b1;
    check("bready", 64'(bready_in), 64'd1);
    k = 0; fin = 1'b0;
    while (!fin) begin
      k++;
      axi_bvalid = (k == bdly);
      axi_bresp  = br;
      check("no_early_done", 64'(done), 64'd0);
      @(negedge clk); lat++;
      fin = axi_bvalid || (k >= TO);
    end
    axi_bvalid = 1'b0;
    er = (bdly >= 1 && bdly <= TO) ? br : 2'b11;
    check("done", 64'(done), 64'd1);
    check("done_resp", 64'(done_resp), 64'(er));
    check("bready_fall", 64'(bready_in), 64'd0);
    if (full_rate && bdly == 1) check("latency", 64'(lat), 64'(l) + 64'd4);
    @(negedge clk);
    check("done_pulse", 64'(done), 64'd0);
    check("idle_ready", 64'({cmd_ready, busy}), 64'd2);
    check("wlast_err", 64'(wlast_err), 64'(exp_werr));
  endtask

  initial begin
    logic [7:0] rl;
    logic [2:0] rs;
    logic [1:0] rb;
    rst = 1'b1; cmd_valid = 1'b0; cmd_addr = 32'd0; cmd_len = 8'd0; cmd_size = 3'd0;
    cmd_burst = 2'd0; din_valid = 1'b0; din_data = 64'd0; axi_awready = 1'b0;
    axi_wready = 1'b0; axi_wlast = 1'b0; axi_bvalid = 1'b0; axi_bresp = 2'd0;
    repeat (3) @(negedge clk);
    check("rst_ready_busy", 64'({cmd_ready, busy}), 64'd2);
    check("rst_outs", 64'({awvalid_in, bready_in, done, done_resp, wlast_err, wstrb_in}), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    run_cmd(32'h1000, 8'd3, 3'd3, 2'd1, 1, 2'b00, 1'b1, 1'b0);
    run_cmd(32'h1003, 8'd1, 3'd2, 2'd1, 1, 2'b00, 1'b1, 1'b0);
    run_cmd(32'h1018, 8'd3, 3'd3, 2'd2, 1, 2'b01, 1'b1, 1'b0);
    run_cmd(32'h1002, 8'd2, 3'd1, 2'd0, 3, 2'b00, 1'b0, 1'b0);
    run_cmd(32'h1000, 8'd0, 3'd4, 2'd1, 1, 2'b00, 1'b1, 1'b0);
    run_cmd(32'h1000, 8'd2, 3'd3, 2'd2, 1, 2'b00, 1'b1, 1'b0);
    run_cmd(32'h1000, 8'd0, 3'd0, 2'd3, 1, 2'b00, 1'b1, 1'b0);
    run_cmd(32'h2000, 8'd1, 3'd3, 2'd1, 0, 2'b00, 1'b1, 1'b0);
    run_cmd(32'h2000, 8'd1, 3'd3, 2'd1, TO, 2'b10, 1'b1, 1'b0);
    run_cmd(32'hFFFF_FFF8, 8'd2, 3'd3, 2'd1, 2, 2'b00, 1'b0, 1'b0);

    for (int i = 0; i < 25; i++) begin
      rb = 2'($urandom_range(0, 2));
      rs = 3'($urandom_range(0, 3));
      rl = (rb == 2'd2) ? 8'((1 << $urandom_range(1, 4)) - 1) : 8'($urandom_range(0, 15));
      run_cmd($urandom, rl, rs, rb, int'($urandom_range(1, 20)), 2'($urandom_range(0, 3)),
              1'b0, 1'b0);
    end

    // Abort a len-7 burst while its third beat is on the bus.
    cmd_valid = 1'b1; cmd_addr = 32'h3000; cmd_len = 8'd7; cmd_size = 3'd3; cmd_burst = 2'd1;
    @(negedge clk);
    cmd_valid = 1'b0; axi_awready = 1'b1;
    @(negedge clk);
    axi_awready = 1'b0; din_valid = 1'b1; din_data = 64'h1234; axi_wready = 1'b1;
    repeat (2) @(negedge clk);
    check("pre_rst_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_ready_busy", 64'({cmd_ready, busy}), 64'd2);
    check("abort_outs", 64'({awvalid_in, wvalid_in, din_ready, bready_in, done, wstrb_in}), 64'd0);
    din_valid = 1'b0; axi_wready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_no_done", 64'(done), 64'd0);
    end
    run_cmd(32'h3000, 8'd7, 3'd3, 2'd1, 1, 2'b00, 1'b1, 1'b0);

    run_cmd(32'h4000, 8'd2, 3'd3, 2'd1, 1, 2'b00, 1'b1, 1'b1);
    run_cmd(32'h4100, 8'd1, 3'd2, 2'd1, 1, 2'b00, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_werr = 1'b0;
    check("werr_cleared", 64'(wlast_err), 64'(exp_werr));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
